kirby_input_ctrl: RTL and testbench

//  Converts raw USB-HID keycode into per-frame motion commands for the Kirby sprite stage directly downstream.

---
 rtl/kirby_pkg.sv | 39 +++
 rtl/frame_tick_gen.sv | 33 +++
 rtl/kirby_input_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_kirby_input_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/kirby_pkg.sv
// kirby_pkg: shared types and constants for the Kirby input controller.
//   action_t      3-bit action encoding driven on kirby_input_ctrl.action
//   KEY_*         HID keycodes the controller reacts to
//   DEF_*         default step sizes and jump length
//   sanitize_key  maps any keycode the controller does not use to KEY_NONE
package kirby_pkg;

    typedef enum logic [2:0] {
        ActIdle   = 3'd0,
        ActWalk   = 3'd1,
        ActJump   = 3'd2,
        ActFall   = 3'd3,
        ActFloat  = 3'd4,
        ActInhale = 3'd5
    } action_t;

    localparam logic [7:0] KEY_NONE = 8'h00;
    localparam logic [7:0] KEY_A    = 8'h04;
    localparam logic [7:0] KEY_D    = 8'h07;
    localparam logic [7:0] KEY_W    = 8'h1A;
    localparam logic [7:0] KEY_S    = 8'h16;
    localparam logic [7:0] KEY_J    = 8'h0D;

    localparam logic signed [9:0] DEF_WALK_STEP   = 10'sd1;
    localparam logic signed [9:0] DEF_JUMP_STEP   = 10'sd3;
    localparam logic signed [9:0] DEF_FALL_MAX    = 10'sd4;
    localparam logic signed [9:0] DEF_FLOAT_STEP  = 10'sd1;
    localparam logic [4:0]        DEF_JUMP_FRAMES = 5'd12;

    function automatic logic [7:0] sanitize_key(input logic [7:0] code);
        logic [7:0] result;
        case (code)
            KEY_A, KEY_D, KEY_W, KEY_S, KEY_J: result = code;
            default:                           result = KEY_NONE;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: brings an asynchronous frame clock into the Clk domain and
// emits a one-Clk pulse per rising edge. Tick appears 3 Clk after frame_clk rises.
//   Clk        in   system clock
//   Reset_n    in   asynchronous reset, active-low
//   frame_clk  in   frame-rate clock, asynchronous to Clk
//   frame_tick out  registered one-Clk pulse per frame_clk rising edge
`timescale 1ns/1ps
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic frame_tick
);

    logic [1:0] sync_q;
    logic       prev_q;
    logic       tick_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], frame_clk};
            prev_q <= sync_q[1];
            tick_q <= sync_q[1] & ~prev_q;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/kirby_input_ctrl.sv
// kirby_input_ctrl: turns the current HID keycode into per-frame motion commands
// (x_step/y_step/facing/action) for the Kirby sprite stage. State advances only
// on the Clk cycle where frame_tick is high; outputs hold between frames.
//   Clk          in   system clock
//   Reset_n      in   asynchronous reset, active-low
//   frame_clk    in   frame clock, asynchronous to Clk
//   keycode      in   current HID keycode, 8'h00 = none
//   on_ground    in   sprite stage reports Kirby resting on the floor
//   frame_tick   out  one-Clk pulse per frame
//   x_step       out  signed horizontal step for this frame
//   y_step       out  signed vertical step, positive = down
//   facing_left  out  sprite orientation
//   action       out  action_t encoding of the current action
// Build option: define KIRBY_DASH_EN to enable double-tap dash (2x walk step).
`timescale 1ns/1ps
module kirby_input_ctrl
    import kirby_pkg::*;
#(
    parameter logic signed [9:0] WALK_STEP   = DEF_WALK_STEP,
    parameter logic signed [9:0] JUMP_STEP   = DEF_JUMP_STEP,
    parameter logic [4:0]        JUMP_FRAMES = DEF_JUMP_FRAMES,
    parameter logic signed [9:0] FALL_MAX    = DEF_FALL_MAX,
    parameter logic signed [9:0] FLOAT_STEP  = DEF_FLOAT_STEP
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       on_ground,
    output logic       frame_tick,
    output logic [9:0] x_step,
    output logic [9:0] y_step,
    output logic       facing_left,
    output logic [2:0] action
);

    action_t           action_q, action_d;
    logic signed [9:0] x_step_q, x_step_d;
    logic signed [9:0] y_step_q, y_step_d;
    logic              facing_q, facing_d;
    logic [4:0]        jump_cnt_q, jump_cnt_d;
    logic [7:0]        last_key_q, last_key_d;

    logic [7:0]        key;
    logic              w_edge;
    logic              go_left;
    logic              go_right;
    logic signed [9:0] walk_mag;

`ifdef KIRBY_DASH_EN
    localparam logic [3:0] DASH_WINDOW = 4'd8;

    logic       dash_q, dash_d;
    logic       armed_q, armed_d;
    logic [1:0] rel_dir_q, rel_dir_d;
    logic [3:0] gap_q, gap_d;
    logic [1:0] dir;
    logic [1:0] last_dir;
`endif

    frame_tick_gen u_frame_tick_gen (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            action_q   <= ActIdle;
            x_step_q   <= '0;
            y_step_q   <= '0;
            facing_q   <= 1'b0;
            jump_cnt_q <= '0;
            last_key_q <= KEY_NONE;
`ifdef KIRBY_DASH_EN
            dash_q     <= 1'b0;
            armed_q    <= 1'b0;
            rel_dir_q  <= 2'b00;
            gap_q      <= '0;
`endif
        end else if (frame_tick) begin
            action_q   <= action_d;
            x_step_q   <= x_step_d;
            y_step_q   <= y_step_d;
            facing_q   <= facing_d;
            jump_cnt_q <= jump_cnt_d;
            last_key_q <= last_key_d;
`ifdef KIRBY_DASH_EN
            dash_q     <= dash_d;
            armed_q    <= armed_d;
            rel_dir_q  <= rel_dir_d;
            gap_q      <= gap_d;
`endif
        end
    end

    // Next-state for one frame; only committed when frame_tick is high.
    always_comb begin
        key        = sanitize_key(keycode);
        w_edge     = (key == KEY_W) && (last_key_q != KEY_W);
        go_left    = (key == KEY_A);
        go_right   = (key == KEY_D);
        last_key_d = key;

`ifdef KIRBY_DASH_EN
        dir       = {go_left, go_right};
        last_dir  = {last_key_q == KEY_A, last_key_q == KEY_D};
        dash_d    = dash_q;
        armed_d   = armed_q;
        rel_dir_d = rel_dir_q;
        gap_d     = gap_q;
        if (dir != 2'b00) begin
            // A fresh press dashes only if it repeats the direction just released.
            if (dir != last_dir) begin
                dash_d  = armed_q && (rel_dir_q == dir) && (gap_q <= DASH_WINDOW);
                armed_d = 1'b0;
            end
        end else begin
            dash_d = 1'b0;
            if (last_dir != 2'b00) begin
                armed_d   = 1'b1;
                rel_dir_d = last_dir;
                gap_d     = 4'd1;
            end else if (gap_q != 4'hF) begin
                gap_d = gap_q + 4'd1;
            end
        end
        if (action_q == ActInhale || key == KEY_J) begin
            dash_d  = 1'b0;
            armed_d = 1'b0;
        end
        walk_mag = dash_d ? (WALK_STEP <<< 1) : WALK_STEP;
`else
        walk_mag = WALK_STEP;
`endif

        // Horizontal steering applies everywhere except while inhaling.
        facing_d = facing_q;
        if (action_q == ActInhale) begin
            x_step_d = '0;
        end else if (go_left) begin
            x_step_d = -walk_mag;
            facing_d = 1'b1;
        end else if (go_right) begin
            x_step_d = walk_mag;
            facing_d = 1'b0;
        end else begin
            x_step_d = '0;
        end

        action_d   = action_q;
        y_step_d   = y_step_q;
        jump_cnt_d = jump_cnt_q;
        unique case (action_q)
            ActIdle, ActWalk: begin
                y_step_d = '0;
                if (!on_ground) begin
                    action_d = ActFall;
                end else if (w_edge) begin
                    action_d   = ActJump;
                    y_step_d   = -JUMP_STEP;
                    jump_cnt_d = '0;
                end else if (key == KEY_J) begin
                    action_d = ActInhale;
                end else if (go_left || go_right) begin
                    action_d = ActWalk;
                end else begin
                    action_d = ActIdle;
                end
            end
            ActJump: begin
                if (jump_cnt_q == JUMP_FRAMES - 5'd1) begin
                    action_d   = ActFall;
                    y_step_d   = '0;
                    jump_cnt_d = '0;
                end else begin
                    jump_cnt_d = jump_cnt_q + 5'd1;
                    y_step_d   = -JUMP_STEP;
                end
            end
            ActFall: begin
                // Landing takes priority over a float request in the same frame.
                if (on_ground) begin
                    action_d = ActIdle;
                    y_step_d = '0;
                end else if (w_edge) begin
                    action_d = ActFloat;
                    y_step_d = FLOAT_STEP;
                end else if (y_step_q >= FALL_MAX) begin
                    y_step_d = FALL_MAX;
                end else begin
                    y_step_d = y_step_q + 10'sd1;
                end
            end
            ActFloat: begin
                if (on_ground) begin
                    action_d = ActIdle;
                    y_step_d = '0;
                end else if (key == KEY_S) begin
                    action_d = ActFall;
                    y_step_d = '0;
                end else begin
                    y_step_d = FLOAT_STEP;
                end
            end
            ActInhale: begin
                y_step_d = '0;
                if (!on_ground) begin
                    action_d = ActFall;
                end else if (key != KEY_J) begin
                    action_d = ActIdle;
                end
            end
            default: begin
                action_d = ActIdle;
                y_step_d = '0;
            end
        endcase
    end

    assign x_step      = x_step_q;
    assign y_step      = y_step_q;
    assign facing_left = facing_q;
    assign action      = action_q;

endmodule

// File: tb/tb_kirby_input_ctrl.sv
// Directed bench for kirby_input_ctrl. Each frame pushes its hand-computed
// expected outputs into a queue; a monitor pops one entry per frame_tick.
`timescale 1ns/1ps
module tb_kirby_input_ctrl;

    localparam logic [2:0] IDLE = 3'd0, WALK = 3'd1, JUMP = 3'd2;
    localparam logic [2:0] FALL = 3'd3, FLOAT = 3'd4, INHALE = 3'd5;
    localparam logic [7:0] K0 = 8'h00, KA = 8'h04, KD = 8'h07, KW = 8'h1A;
    localparam logic [7:0] KS = 8'h16, KJ = 8'h0D, KX = 8'h55;
`ifdef KIRBY_DASH_EN
    localparam int DASH_X = 2;
`else
    localparam int DASH_X = 1;
`endif

    typedef struct {
        logic [2:0]        act;
        logic signed [9:0] x;
        logic signed [9:0] y;
        logic              face;
        int                n;
    } exp_t;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              frame_clk = 1'b0;
    logic [7:0]        keycode = 8'h00;
    logic              on_ground = 1'b1;
    logic              frame_tick;
    logic signed [9:0] x_step;
    logic signed [9:0] y_step;
    logic              facing_left;
    logic [2:0]        action;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   frame_no = 0;

    always #10 Clk = ~Clk;

    kirby_input_ctrl dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .keycode     (keycode),
        .on_ground   (on_ground),
        .frame_tick  (frame_tick),
        .x_step      (x_step),
        .y_step      (y_step),
        .facing_left (facing_left),
        .action      (action)
    );

    task automatic chk(input string name, input bit ok, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    function automatic string outs_str();
        return $sformatf("act=%0d x=%0d y=%0d face=%0b tick=%0b",
                         action, x_step, y_step, facing_left, frame_tick);
    endfunction

    // One frame: apply inputs, queue expected outputs, pulse frame_clk.
    task automatic frame(input logic [7:0] k, input logic og, input logic [2:0] ea,
                         input int ex, input int ey, input logic ef);
        exp_t e;
        int   lat;
        e.act  = ea;
        e.x    = ex[9:0];
        e.y    = ey[9:0];
        e.face = ef;
        e.n    = frame_no;
        frame_no++;
        exp_q.push_back(e);
        @(negedge Clk);
        keycode   = k;
        on_ground = og;
        @(negedge Clk);
        frame_clk = 1'b1;
        lat = 0;
        while (frame_tick !== 1'b1 && lat < 8) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        chk("tick_latency", (frame_tick === 1'b1) && (lat <= 3),
            $sformatf("frame %0d got %0d Clk (tick=%0b), required <=3", e.n, lat, frame_tick));
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    // Monitor: each frame_tick commits one frame; compare just after that edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (frame_tick === 1'b1) begin
                @(posedge Clk);
                #1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_tick", 1'b0, $sformatf("got %s, required no tick", outs_str()));
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("frame%0d", e.n),
                        action === e.act && x_step === e.x && y_step === e.y &&
                        facing_left === e.face,
                        $sformatf("got %s, required act=%0d x=%0d y=%0d face=%0b",
                                  outs_str(), e.act, e.x, e.y, e.face));
                end
                @(negedge Clk);
                chk("tick_width", frame_tick === 1'b0,
                    $sformatf("got tick=%0b one Clk later, required 0", frame_tick));
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got no finish within 5 ms, required completion");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge Clk);
        chk("reset_state", action === IDLE && x_step === 10'sd0 && y_step === 10'sd0 &&
            facing_left === 1'b0 && frame_tick === 1'b0,
            $sformatf("got %s, required all zero", outs_str()));
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);

        // Walking right, then left; facing holds once keys are released.
        for (int i = 0; i < 3; i++) frame(KD, 1, WALK, 1, 0, 0);
        frame(K0, 1, IDLE, 0, 0, 0);
        frame(KA, 1, WALK, -1, 0, 1);
        frame(K0, 1, IDLE, 0, 0, 1);
        frame(KX, 1, IDLE, 0, 0, 1);

        // Jump: 12 frames rising, steerable, then accelerating fall and landing.
        frame(KW, 1, JUMP, 0, -3, 1);
        for (int i = 0; i < 3; i++) frame(K0, 0, JUMP, 0, -3, 1);
        frame(KD, 0, JUMP, 1, -3, 0);
        for (int i = 0; i < 7; i++) frame(K0, 0, JUMP, 0, -3, 0);
        frame(K0, 0, FALL, 0, 0, 0);
        frame(K0, 0, FALL, 0, 1, 0);
        frame(K0, 0, FALL, 0, 2, 0);
        frame(KA, 0, FALL, -1, 3, 1);
        frame(K0, 0, FALL, 0, 4, 1);
        frame(K0, 0, FALL, 0, 4, 1);
        frame(K0, 1, IDLE, 0, 0, 1);

        // Ledge fall, held W floats once, S cancels, landing beats float.
        frame(K0, 0, FALL, 0, 0, 1);
        frame(KW, 0, FLOAT, 0, 1, 1);
        for (int i = 0; i < 4; i++) frame(KW, 0, FLOAT, 0, 1, 1);
        frame(KS, 0, FALL, 0, 0, 1);
        frame(K0, 0, FALL, 0, 1, 1);
        frame(KW, 1, IDLE, 0, 0, 1);
        frame(KW, 1, IDLE, 0, 0, 1);

        // Inhale ignores steering; losing ground drops into a fall.
        frame(KJ, 1, INHALE, 0, 0, 1);
        frame(KJ, 1, INHALE, 0, 0, 1);
        frame(KD, 1, IDLE, 0, 0, 1);
        frame(KJ, 1, INHALE, 0, 0, 1);
        frame(KJ, 0, FALL, 0, 0, 1);
        frame(K0, 1, IDLE, 0, 0, 1);

        // Double tap: too slow first, then within the window.
        frame(KD, 1, WALK, 1, 0, 0);
        for (int i = 0; i < 9; i++) frame(K0, 1, IDLE, 0, 0, 0);
        frame(KD, 1, WALK, 1, 0, 0);
        frame(KJ, 1, INHALE, 0, 0, 0);
        frame(K0, 1, IDLE, 0, 0, 0);
        frame(KD, 1, WALK, 1, 0, 0);
        frame(K0, 1, IDLE, 0, 0, 0);
        frame(KD, 1, WALK, DASH_X, 0, 0);
        frame(KD, 1, WALK, DASH_X, 0, 0);
        frame(K0, 1, IDLE, 0, 0, 0);

        // Reset mid-jump clears state and W history.
        frame(KW, 1, JUMP, 0, -3, 0);
        frame(KW, 0, JUMP, 0, -3, 0);
        @(negedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("reset_mid_jump", action === IDLE && x_step === 10'sd0 && y_step === 10'sd0 &&
            facing_left === 1'b0 && frame_tick === 1'b0,
            $sformatf("got %s, required all zero", outs_str()));
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        frame(KW, 1, JUMP, 0, -3, 0);
        frame(K0, 0, JUMP, 0, -3, 0);

        repeat (10) @(negedge Clk);
        chk("queue_drained", exp_q.size() == 0,
            $sformatf("got %0d frames without a tick, required 0", exp_q.size()));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
